// File: rtl/key_debounce.sv
// Push-button debouncer: 2-FF synchroniser, IDLE/P_FILT/DOWN/R_FILT filter FSM, registered events.
// Optional long-press pulse when KEY_LONG_PRESS_EN is defined; otherwise key_long is tied low.
module key_debounce #(
  parameter int unsigned FILTER_CNT = 1000000,
  parameter bit          KEY_ACTIVE = 1'b0,
  parameter int unsigned LONG_CNT   = 50000000
) (
  input  logic sclk,
  input  logic rst,
  input  logic key_in,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CntW = ($clog2(FILTER_CNT) > 1) ? $clog2(FILTER_CNT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(FILTER_CNT - 1);

  typedef enum logic [1:0] {StIdle, StPFilt, StDown, StRFilt} state_e;

  logic      sync1_q, sync2_q;
  logic      key_act;
  state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic      press_d, release_d;

  // Synchroniser resets to the released level so reset release never looks like a press.
  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      sync1_q <= ~KEY_ACTIVE;
      sync2_q <= ~KEY_ACTIVE;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign key_act = (sync2_q == KEY_ACTIVE);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (key_act) begin
          state_d = StPFilt;
          cnt_d   = '0;
        end
      end
      StPFilt: begin
        if (!key_act) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StDown;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDown: begin
        if (!key_act) begin
          state_d = StRFilt;
          cnt_d   = '0;
        end
      end
      StRFilt: begin
        if (key_act) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_state   <= (state_d == StDown) || (state_d == StRFilt);
      key_press   <= press_d;
      key_release <= release_d;
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LongW = ($clog2(LONG_CNT) > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [LongW-1:0] LongLast = LongW'(LONG_CNT - 1);

  logic [LongW-1:0] lcnt_q, lcnt_d;
  logic             fired_q, fired_d;
  logic             long_d;

  // Counter saturates at LongLast; fired_q keeps it to one pulse per press, even across R_FILT.
  always_comb begin
    lcnt_d  = lcnt_q;
    fired_d = fired_q;
    long_d  = 1'b0;
    unique case (state_q)
      StIdle, StPFilt: begin
        lcnt_d  = '0;
        fired_d = 1'b0;
      end
      StDown: begin
        if (lcnt_q != LongLast) begin
          lcnt_d = lcnt_q + 1'b1;
        end else if (!fired_q) begin
          long_d  = 1'b1;
          fired_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge sclk or posedge rst) begin
    if (rst) begin
      lcnt_q   <= '0;
      fired_q  <= 1'b0;
      key_long <= 1'b0;
    end else begin
      lcnt_q   <= lcnt_d;
      fired_q  <= fired_d;
      key_long <= long_d;
    end
  end
`else
  logic unused_long_cnt;
  assign unused_long_cnt = ^LONG_CNT;
  assign key_long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Scoreboard bench for key_debounce: stimulus pushes expected events with their cycle,
// a negedge monitor pops and compares whenever the DUT pulses an event output.
module tb_key_debounce;

  localparam int LAT      = 7;   // FILTER_CNT + 3 edges from key change to event
  localparam int LONG_LAT = 10;  // press to key_long

  localparam int EvPress   = 0;
  localparam int EvRelease = 1;
  localparam int EvLong    = 2;

  logic sclk = 1'b0;
  logic rst;
  logic key_in;
  logic key_state, key_press, key_release, key_long;

  key_debounce #(
    .FILTER_CNT(4),
    .KEY_ACTIVE(1'b0),
    .LONG_CNT  (10)
  ) dut (
    .sclk       (sclk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int at;
  } ev_t;
  ev_t exp_q[$];

  int n_checks   = 0;
  int n_fail     = 0;
  int n_long_exp = 0;
  int n_long_obs = 0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_cycle", cyc, e.at);
    end
  endtask

  always @(negedge sclk) begin
    if (!rst && (key_press || key_release || key_long)) begin
      check("press_release_exclusive", int'(key_press & key_release), 0);
      if (key_press)   pop_ev(EvPress);
      if (key_release) pop_ev(EvRelease);
      if (key_long) begin
        n_long_obs++;
        pop_ev(EvLong);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sclk);
    #1;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout, required end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int e;
    rst    = 1'b1;
    key_in = 1'b1;
    tick(3);
    check("reset_key_state", key_state, 0);
    check("reset_key_press", key_press, 0);
    check("reset_key_release", key_release, 0);

    // Key held through reset: full filter after release
    key_in = 1'b0;
    tick(2);
    check("held_in_reset_state", key_state, 0);
    rst = 1'b0;
    e = cyc;
    expect_ev(EvPress, e + LAT);
    tick(LAT - 1);
    check("t1_state_pre", key_state, 0);
    tick(1);
    check("t1_state_post", key_state, 1);
    check("t1_press_level", key_press, 1);
    key_in = 1'b1;
    e = cyc;
    expect_ev(EvRelease, e + LAT);
    tick(LAT);
    check("t1_release_state", key_state, 0);
    tick(2);

    // Bounces shorter than the filter never produce an event
    for (int i = 0; i < 5; i++) begin
      key_in = 1'b0;
      tick(3);
      key_in = 1'b1;
      tick(4);
      check("bounce_state", key_state, 0);
    end

    // Clean press held 30 cycles
    key_in = 1'b0;
    e = cyc;
    expect_ev(EvPress, e + LAT);
`ifdef KEY_LONG_PRESS_EN
    expect_ev(EvLong, e + LAT + LONG_LAT);
    n_long_exp++;
`endif
    tick(30);
    check("t3_held_state", key_state, 1);
    key_in = 1'b1;
    e = cyc;
    expect_ev(EvRelease, e + LAT);
    tick(LAT - 1);
    check("t3_state_pre_release", key_state, 1);
    tick(1);
    check("t3_state_post_release", key_state, 0);
    tick(2);

    // Release glitch of 2 cycles while DOWN is rejected
    key_in = 1'b0;
    e = cyc;
    expect_ev(EvPress, e + LAT);
    tick(8);
    key_in = 1'b1;
    tick(2);
    key_in = 1'b0;
    tick(2);
    check("glitch_state", key_state, 1);
    key_in = 1'b1;
    e = cyc;
    expect_ev(EvRelease, e + LAT);
    tick(LAT);
    check("t4_release_state", key_state, 0);
    tick(2);

    // Asynchronous reset while DOWN: no release, press refilters
    key_in = 1'b0;
    e = cyc;
    expect_ev(EvPress, e + LAT);
    tick(8);
    check("t5_down_state", key_state, 1);
    rst = 1'b1;
    #1;
    check("t5_async_reset_state", key_state, 0);
    tick(1);
    rst = 1'b0;
    e = cyc;
    expect_ev(EvPress, e + LAT);
    tick(LAT - 1);
    check("t5_state_pre", key_state, 0);
    tick(1);
    check("t5_state_post", key_state, 1);
    key_in = 1'b1;
    e = cyc;
    expect_ev(EvRelease, e + LAT);
    tick(LAT + 2);

    tick(5);
    check("queue_drained", exp_q.size(), 0);
    check("long_pulse_count", n_long_obs, n_long_exp);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
